font_rom_arbiter: RTL and testbench

- Shares the single synchronous font ROM port between the terminal's text writers: basket price column, item-name column and total line.
- Each writer requests one glyph row, given as a char code plus row index. The arbiter grants requests round-robin, drives the ROM address and routes the returned 8-pixel row back to the requester with fixed latency.
- Sits between the VGA text writers and the font ROM, clocked by the pixel clock.

---
 rtl/font_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 51 +++++
 rtl/font_rom_arbiter.sv | 97 +++++++++
 tb/tb_font_rom_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/font_pkg.sv
// Shared font ROM arbiter constants, tag entry type and glyph address helper.
package font_pkg;

  localparam int N_REQ   = 3;
  localparam int CHAR_W  = 7;
  localparam int ROW_W   = 4;
  localparam int DATA_W  = 8;
  localparam int ROM_LAT = 1;
  localparam int IDX_W   = 2;
  localparam int ADDR_W  = CHAR_W + ROW_W;

  localparam logic [CHAR_W-1:0] BLANK_CODE = 7'h7F;

  localparam logic [IDX_W-1:0] REQ_PRICE = 2'd0;
  localparam logic [IDX_W-1:0] REQ_NAME  = 2'd1;
  localparam logic [IDX_W-1:0] REQ_TOTAL = 2'd2;

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
    logic             blank;
  } tag_t;

  function automatic logic [ADDR_W-1:0] glyph_addr(input logic [CHAR_W-1:0] chr,
                                                   input logic [ROW_W-1:0]  row);
    return {chr, row};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Generic N-way round-robin arbiter: combinational one-hot grant from current requests,
// search starts at the pointer; pointer moves past the winner, clr_i forces it to 0.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic [N-1:0]     req_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_vld_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W:0]   cand;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N)) cand = cand - (IDX_W+1)'(N);
      if (!gnt_vld_o && req_i[cand[IDX_W-1:0]]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = cand[IDX_W-1:0];
      end
    end
    // No grants while reset is held, so nothing is accepted and then dropped.
    if (rst_i) begin
      gnt_vld_o = 1'b0;
      gnt_idx_o = '0;
    end
    if (gnt_vld_o) gnt_o[gnt_idx_o] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_vld_o) ptr_d = (gnt_idx_o == IDX_W'(N-1)) ? '0 : gnt_idx_o + IDX_W'(1);
    if (clr_i) ptr_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/font_rom_arbiter.sv
// Shares one synchronous font ROM between the text writers; responses return in grant
// order ROM_LAT+2 cycles after the handshake. Blank chars bypass the ROM but keep their slot.
module font_rom_arbiter
  import font_pkg::*;
(
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    frame_sync,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*CHAR_W-1:0] req_char,
  input  logic [N_REQ*ROW_W-1:0]  req_row,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    rom_en,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [DATA_W-1:0]       rom_data
);

  logic [N_REQ-1:0]  gnt;
  logic [IDX_W-1:0]  gnt_idx;
  logic              gnt_vld;
  logic [CHAR_W-1:0] sel_char;
  logic [ROW_W-1:0]  sel_row;
  logic              sel_blank;

  logic              rom_en_q, rom_en_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  tag_t              tag_q [ROM_LAT+1];
  tag_t              tag_d [ROM_LAT+1];
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .clk_i     (CLK),
    .rst_i     (RST),
    .clr_i     (frame_sync),
    .req_i     (req_valid),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  always_comb begin
    sel_char = '0;
    sel_row  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == IDX_W'(i)) begin
        sel_char = req_char[i*CHAR_W +: CHAR_W];
        sel_row  = req_row[i*ROW_W +: ROW_W];
      end
    end
    sel_blank = (sel_char == BLANK_CODE);
  end

  always_comb begin
    rom_en_d   = gnt_vld & ~sel_blank;
    rom_addr_d = rom_en_d ? glyph_addr(sel_char, sel_row) : rom_addr_q;

    tag_d[0] = '{vld: gnt_vld, idx: gnt_idx, blank: sel_blank};
    for (int k = 1; k <= ROM_LAT; k++) tag_d[k] = tag_q[k-1];

    // The last tag stage lines up with the cycle rom_data is valid.
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (tag_q[ROM_LAT].vld) begin
      rsp_valid_d[tag_q[ROM_LAT].idx] = 1'b1;
      rsp_data_d = tag_q[ROM_LAT].blank ? '0 : rom_data;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rom_en_q    <= 1'b0;
      rom_addr_q  <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      for (int k = 0; k <= ROM_LAT; k++) tag_q[k] <= '0;
    end else begin
      rom_en_q    <= rom_en_d;
      rom_addr_q  <= rom_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      for (int k = 0; k <= ROM_LAT; k++) tag_q[k] <= tag_d[k];
    end
  end

  assign req_ready = gnt;
  assign rom_en    = rom_en_q;
  assign rom_addr  = rom_addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Scoreboard bench: reference arbiter + ROM model predict grants, ROM issue and responses.
module tb_font_rom_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        frame_sync = 1'b0;
  logic [2:0]  req_valid = '0;
  logic [20:0] req_char = '0;
  logic [11:0] req_row = '0;
  logic [2:0]  req_ready, rsp_valid;
  logic [7:0]  rsp_data, rom_data;
  logic        rom_en;
  logic [10:0] rom_addr;
  logic [7:0]  rom_q = 8'h00;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         due;
    logic [2:0] vld;
    logic [7:0] dat;
  } exp_t;

  exp_t        q[$];
  int          ptr_m = 0;
  logic        exp_en = 1'b0;
  logic [10:0] exp_addr = '0;
  logic [2:0]  last_rdy = '0;

  font_rom_arbiter dut (
    .CLK        (CLK),
    .RST        (RST),
    .frame_sync (frame_sync),
    .req_valid  (req_valid),
    .req_char   (req_char),
    .req_row    (req_row),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rom_en     (rom_en),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] rom_fn(input logic [10:0] a);
    return a[7:0] ^ {a[10:8], a[10:6]} ^ 8'h3C;
  endfunction

  always @(posedge CLK) if (rom_en) rom_q <= rom_fn(rom_addr);
  assign rom_data = rom_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic monitor();
    int         gi;
    int         c;
    logic       found;
    logic [2:0] g;
    logic [6:0] ch;
    logic [3:0] rw;
    logic       blank;
    cyc++;
    last_rdy = req_ready;
    if (RST) begin
      check("rst_req_ready", 32'(req_ready), 0);
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_rsp_data", 32'(rsp_data), 0);
      check("rst_rom_en", 32'(rom_en), 0);
      check("rst_rom_addr", 32'(rom_addr), 0);
      ptr_m  = 0;
      exp_en = 1'b0;
      q.delete();
    end else begin
      check("rom_en", 32'(rom_en), 32'(exp_en));
      if (exp_en) check("rom_addr", 32'(rom_addr), 32'(exp_addr));

      if (q.size() > 0 && q[0].due == cyc) begin
        check("rsp_valid", 32'(rsp_valid), 32'(q[0].vld));
        check("rsp_data", 32'(rsp_data), 32'(q[0].dat));
        void'(q.pop_front());
      end else if (rsp_valid != 3'b000) begin
        check("rsp_spurious", 32'(rsp_valid), 0);
      end

      found = 1'b0;
      gi    = 0;
      g     = '0;
      for (int k = 0; k < 3; k++) begin
        c = (ptr_m + k) % 3;
        if (!found && req_valid[2'(c)]) begin
          found = 1'b1;
          gi    = c;
        end
      end
      if (found) g[2'(gi)] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(g));

      exp_en = 1'b0;
      if (found) begin
        ch    = 7'(req_char >> (7 * gi));
        rw    = 4'(req_row >> (4 * gi));
        blank = (ch == 7'h7F);
        exp_en = ~blank;
        if (!blank) exp_addr = {ch, rw};
        q.push_back('{due: cyc + 3, vld: g, dat: blank ? 8'h00 : rom_fn({ch, rw})});
        ptr_m = (gi + 1) % 3;
      end
      if (frame_sync) ptr_m = 0;
    end
  endtask

  task automatic step(input logic rst, input logic [2:0] v, input logic [20:0] ch,
                      input logic [11:0] rw, input logic fs);
    RST        = rst;
    req_valid  = v;
    req_char   = ch;
    req_row    = rw;
    frame_sync = fs;
    @(negedge CLK);
    monitor();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'b000, '0, '0, 1'b0);
  endtask

  initial begin
    logic [20:0] rch;
    logic [11:0] rrw;
    logic [6:0]  c7;
    logic        hit;

    for (int i = 0; i < 3; i++) step(1'b1, 3'b000, '0, '0, 1'b0);
    idle(1);

    // single request from requester 0
    step(1'b0, 3'b001, {7'h00, 7'h00, 7'h31}, {4'd0, 4'd0, 4'd5}, 1'b0);
    check("single_ready", 32'(last_rdy), 32'h1);
    idle(4);

    // round robin, all valid
    step(1'b0, 3'b000, '0, '0, 1'b1);
    for (int i = 0; i < 6; i++)
      step(1'b0, 3'b111, {7'h20, 7'h45, 7'h12}, {4'(i), 4'(i + 3), 4'(15 - i)}, 1'b0);
    idle(4);

    // blank bypass, alone and mixed into back-to-back traffic
    step(1'b0, 3'b010, {7'h00, 7'h7F, 7'h00}, {4'd0, 4'd3, 4'd0}, 1'b0);
    idle(4);
    for (int i = 0; i < 3; i++)
      step(1'b0, 3'b111, {7'h41, 7'h7F, 7'h30}, {4'd2, 4'd3, 4'd4}, 1'b0);
    idle(4);

    // frame_sync colliding with a grant: pointer to 2, then grant 2 with frame_sync
    step(1'b0, 3'b000, '0, '0, 1'b1);
    step(1'b0, 3'b010, {7'h00, 7'h22, 7'h00}, {4'd0, 4'd1, 4'd0}, 1'b0);
    step(1'b0, 3'b101, {7'h33, 7'h00, 7'h11}, {4'd7, 4'd0, 4'd8}, 1'b1);
    check("fs_collide_grant", 32'(last_rdy), 32'h4);
    step(1'b0, 3'b011, {7'h00, 7'h44, 7'h55}, {4'd0, 4'd9, 4'd10}, 1'b0);
    check("fs_ptr_forced", 32'(last_rdy), 32'h1);
    idle(4);

    // reset while requester 2 is in flight
    step(1'b0, 3'b000, '0, '0, 1'b1);
    step(1'b0, 3'b011, {7'h00, 7'h10, 7'h11}, '0, 1'b0);
    step(1'b0, 3'b100, {7'h55, 7'h00, 7'h00}, {4'd6, 4'd0, 4'd0}, 1'b0);
    step(1'b1, 3'b111, {7'h01, 7'h02, 7'h03}, '0, 1'b0);
    step(1'b1, 3'b111, {7'h01, 7'h02, 7'h03}, '0, 1'b0);
    step(1'b0, 3'b111, {7'h01, 7'h02, 7'h03}, {4'd1, 4'd2, 4'd3}, 1'b0);
    check("post_rst_grant", 32'(last_rdy), 32'h1);
    idle(4);

    // starvation: requester 0 always valid, requester 2 joins
    step(1'b0, 3'b001, {7'h00, 7'h00, 7'h61}, '0, 1'b0);
    step(1'b0, 3'b001, {7'h00, 7'h00, 7'h62}, '0, 1'b0);
    hit = 1'b0;
    for (int n = 0; n < 3; n++) begin
      step(1'b0, 3'b101, {7'h63, 7'h00, 7'h64}, {4'd1, 4'd0, 4'd2}, 1'b0);
      if (last_rdy[2]) begin
        hit = 1'b1;
        break;
      end
    end
    check("starve_bound", 32'(hit), 32'h1);
    idle(4);

    // random traffic
    for (int i = 0; i < 50; i++) begin
      rch = '0;
      rrw = '0;
      for (int r = 0; r < 3; r++) begin
        c7  = ($urandom_range(0, 5) == 0) ? 7'h7F : 7'($urandom);
        rch = (rch << 7) | 21'(c7);
        rrw = (rrw << 4) | 12'($urandom_range(0, 15));
      end
      step(1'b0, 3'($urandom), rch, rrw, ($urandom_range(0, 9) == 0));
    end
    idle(6);
    check("drain", 32'(q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
